pdm_capture_ctrl: RTL

Sequencer for one PDM microphone capture path: PDM clock/CIC datapath, reset-controlled, producing 16-bit PCM with a valid strobe.
- Holds the datapath in reset while idle.
- On start, releases it, waits a fixed microphone settling time, then discards the CIC start-up transient samples.
- Captures a programmed number of samples, or runs until stopped, into a small FIFO drained over an AXI-Stream master with tlast on the final sample.

---
 rtl/pdm_capture_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer for one PDM microphone path. It holds the datapath in
// reset while idle, waits for the microphone to settle, drops the CIC start-up
// transient, then queues PCM samples into a small FIFO. The FIFO drains over
// an AXI-Stream master, and tlast marks the final sample of each capture.
module pdm_capture_ctrl #(
  parameter int SETTLE_CYCLES   = 1000000,
  parameter int DISCARD_SAMPLES = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int LEN_W           = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [LEN_W-1:0]   rec_len,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [LEN_W-1:0]   sample_count,
  output logic               dp_reset,
  input  logic signed [15:0] pcm_in,
  input  logic               pcm_in_valid,
  output logic signed [15:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW = (DISCARD_SAMPLES > 1) ? $clog2(DISCARD_SAMPLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DISC_LAST   = DW'((DISCARD_SAMPLES > 0) ? DISCARD_SAMPLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DISCARD, S_CAPTURE, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     settle_cnt;
  logic [DW-1:0]     disc_cnt;
  logic [LEN_W-1:0]  rec_len_q;
  logic              stop_pending;

  logic [AW:0]       wr_ptr, rd_ptr;
  logic signed [15:0] mem_data [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];

  logic fifo_empty, fifo_full, pop, push, drop, cap_strobe, last_tag;

  // The count saturates in continuous mode instead of wrapping back to zero.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign cap_strobe = (state == S_CAPTURE) && pcm_in_valid;
  // A full FIFO still accepts a sample in the same cycle that a beat leaves.
  assign push       = cap_strobe && (!fifo_full || pop);
  assign drop       = cap_strobe && !push;
  assign last_tag   = stop_pending || stop ||
                      ((rec_len_q != '0) &&
                       (({1'b0, sample_count} + (LEN_W+1)'(1)) == {1'b0, rec_len_q}));

  assign busy          = (state != S_IDLE);
  assign dp_reset      = (state == S_IDLE) || (state == S_DRAIN);
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = mem_data[rd_ptr[AW-1:0]];
  assign m_axis_tlast  = mem_last[rd_ptr[AW-1:0]] && m_axis_tvalid;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. A stop before capture begins goes straight to drain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (stop)                           state_nxt = S_DRAIN;
        else if (settle_cnt == SETTLE_LAST) state_nxt = (DISCARD_SAMPLES == 0) ? S_CAPTURE : S_DISCARD;
      end
      S_DISCARD: begin
        if (stop)                                   state_nxt = S_DRAIN;
        else if (pcm_in_valid && disc_cnt == DISC_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: if (push && last_tag) state_nxt = S_DRAIN;
      S_DRAIN:   if (fifo_empty) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Counters, latched length, stop request and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt   <= '0;
      disc_cnt     <= '0;
      rec_len_q    <= '0;
      stop_pending <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      case (state)
        S_IDLE: if (start) begin
          rec_len_q    <= rec_len;
          overflow     <= 1'b0;
          sample_count <= '0;
          stop_pending <= 1'b0;
          settle_cnt   <= '0;
          disc_cnt     <= '0;
        end
        S_SETTLE:  settle_cnt <= settle_cnt + CW'(1);
        S_DISCARD: if (pcm_in_valid) disc_cnt <= disc_cnt + DW'(1);
        S_CAPTURE: begin
          if (stop) stop_pending <= 1'b1;
          if (push) sample_count <= sat_inc(sample_count);
          if (drop) overflow     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO pointers; the extra top bit separates full from empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage. Data is not reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= pcm_in;
      mem_last[wr_ptr[AW-1:0]] <= last_tag;
    end
  end

endmodule
